// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register with load-use hazard detection.
//
// The decoded operands and control of the instruction in ID are captured and
// presented to EX one cycle later. When the instruction in EX is a load whose
// destination is read by the instruction in ID, a one-cycle bubble is inserted
// and IF/ID is held. By the next edge the load has moved on to MEM, where the
// forwarding unit can pick up its result. A flush kills the slot entering EX.
// An external freeze holds the whole stage.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1/rs2/rd            register addresses from ID
//   id_uses_rs1/rs2          the ID instruction actually reads rs1/rs2
//   id_rs1/rs2_data, id_imm  operand values and immediate
//   id_alu_op, id_alu_src,
//   id_reg_write, id_mem_read,
//   id_mem_write, id_mem_to_reg  control bits
//   flush                    branch taken in EX; kill the instruction entering EX
//   ext_stall                downstream freeze; every EX register holds its value
//   ex_*                     registered copies of the ID fields, seen by EX
//   stall_if_id              combinational hold request for PC and IF/ID
//   bubble_cnt               saturating count of load-use bubbles inserted
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              stall_if_id,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [3:0]        alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } slot_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    slot_t             id_slot_p0;
    slot_t             slot_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  bubble_cnt_p1;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              hazard;

    // ---- stage p0: ID fields and hazard detection ----
    always_comb begin
        id_slot_p0            = '0;
        id_slot_p0.rs1        = id_rs1;
        id_slot_p0.rs2        = id_rs2;
        id_slot_p0.rd         = id_rd;
        id_slot_p0.rs1_data   = id_rs1_data;
        id_slot_p0.rs2_data   = id_rs2_data;
        id_slot_p0.imm        = id_imm;
        id_slot_p0.alu_op     = id_alu_op;
        id_slot_p0.alu_src    = id_alu_src;
        id_slot_p0.reg_write  = id_reg_write;
        id_slot_p0.mem_read   = id_mem_read;
        id_slot_p0.mem_write  = id_mem_write;
        id_slot_p0.mem_to_reg = id_mem_to_reg;
    end

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    // A flush kills the consumer anyway, so no bubble is spent on it.
    assign rs1_hit = id_uses_rs1 && (id_rs1 == slot_p1.rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == slot_p1.rd);
    assign hazard  = id_valid && vld_p1 && slot_p1.mem_read &&
                     (slot_p1.rd != '0) && (rs1_hit || rs2_hit) && !flush;

    assign stall_if_id = hazard || ext_stall;

    // ---- stage p1: ID/EX register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            slot_p1       <= '0;
            bubble_cnt_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            slot_p1 <= '0;
        end else if (ext_stall) begin
            vld_p1  <= vld_p1;
            slot_p1 <= slot_p1;
        end else if (hazard) begin
            // Bubble: an empty slot with every control bit clear, so it can never write back.
            vld_p1        <= 1'b0;
            slot_p1       <= '0;
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end else begin
            vld_p1  <= id_valid;
            slot_p1 <= id_slot_p0;
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_rs1        = slot_p1.rs1;
    assign ex_rs2        = slot_p1.rs2;
    assign ex_rd         = slot_p1.rd;
    assign ex_rs1_data   = slot_p1.rs1_data;
    assign ex_rs2_data   = slot_p1.rs2_data;
    assign ex_imm        = slot_p1.imm;
    assign ex_alu_op     = slot_p1.alu_op;
    assign ex_alu_src    = slot_p1.alu_src;
    assign ex_reg_write  = slot_p1.reg_write;
    assign ex_mem_read   = slot_p1.mem_read;
    assign ex_mem_write  = slot_p1.mem_write;
    assign ex_mem_to_reg = slot_p1.mem_to_reg;
    assign bubble_cnt    = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. A second instance with a 3-bit counter
// shares the same stimulus so that counter saturation is reachable quickly.
module tb_id_ex_stage;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 3;
    localparam int CNT_W   = 16;
    localparam int S_CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_uses_rs1, id_uses_rs2;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [DATA_W-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0] id_alu_op;
    logic id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic flush, ext_stall;

    logic ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall_if_id;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [DATA_W-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [3:0] ex_alu_op;
    logic [CNT_W-1:0] bubble_cnt;

    logic s_ex_valid, s_ex_alu_src, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_mem_to_reg, s_stall_if_id;
    logic [REG_AW-1:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [DATA_W-1:0] s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [3:0] s_ex_alu_op;
    logic [S_CNT_W-1:0] s_bubble_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .ext_stall(ext_stall),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(S_CNT_W)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .ext_stall(ext_stall),
        .ex_valid(s_ex_valid), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
        .ex_alu_op(s_ex_alu_op), .ex_alu_src(s_ex_alu_src), .ex_reg_write(s_ex_reg_write),
        .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_mem_to_reg(s_ex_mem_to_reg),
        .stall_if_id(s_stall_if_id), .bubble_cnt(s_bubble_cnt)
    );

    // One vector: ID inputs for one cycle, expected stall_if_id before the edge
    // and expected EX contents after it. alu_op/imm/alu_src/mem_write/mem_to_reg
    // are derived from the other fields so a cleared slot expects all zeros.
    typedef struct packed {
        logic v; logic [2:0] rs1, rs2, rd; logic u1, u2;
        logic [31:0] d1, d2; logic rw, mr, fl, st;
        logic e_stall, e_v; logic [2:0] e_rd, e_rs1, e_rs2;
        logic [31:0] e_d1, e_d2; logic e_rw, e_mr; logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(int v, int rs1, int rs2, int rd, int u1, int u2, int d1, int d2,
                                int rw, int mr, int fl, int st, int es, int ev, int erd, int ers1,
                                int ers2, int ed1, int ed2, int erw, int emr, int ecnt);
        vec_t r;
        r.v = v[0]; r.rs1 = rs1[2:0]; r.rs2 = rs2[2:0]; r.rd = rd[2:0];
        r.u1 = u1[0]; r.u2 = u2[0]; r.d1 = d1; r.d2 = d2;
        r.rw = rw[0]; r.mr = mr[0]; r.fl = fl[0]; r.st = st[0];
        r.e_stall = es[0]; r.e_v = ev[0]; r.e_rd = erd[2:0]; r.e_rs1 = ers1[2:0]; r.e_rs2 = ers2[2:0];
        r.e_d1 = ed1; r.e_d2 = ed2; r.e_rw = erw[0]; r.e_mr = emr[0]; r.e_cnt = ecnt[15:0];
        return r;
    endfunction

    function automatic vec_t ins(int v, int rs1, int rs2, int rd, int u1, int u2, int d1, int d2,
                                 int rw, int mr, int fl, int st);
        return mk(v, rs1, rs2, rd, u1, u2, d1, d2, rw, mr, fl, st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic int sat3(int c);
        return (c > 7) ? 7 : c;
    endfunction

    task automatic apply(input vec_t x);
        id_valid      = x.v;
        id_rs1        = x.rs1;
        id_rs2        = x.rs2;
        id_rd         = x.rd;
        id_uses_rs1   = x.u1;
        id_uses_rs2   = x.u2;
        id_rs1_data   = x.d1;
        id_rs2_data   = x.d2;
        id_imm        = {x.d2[15:0], x.d1[15:0]};
        id_alu_op     = x.d1[3:0];
        id_alu_src    = x.rw;
        id_reg_write  = x.rw;
        id_mem_read   = x.mr;
        id_mem_write  = x.d2[0];
        id_mem_to_reg = x.mr;
        flush         = x.fl;
        ext_stall     = x.st;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                              input logic [2:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] imm, input logic [3:0] op, input logic asrc,
                              input logic rw, input logic mr, input logic mw, input logic m2r,
                              input vec_t e);
        chk({tag, "_valid"}, 32'(v), 32'(e.e_v));
        chk({tag, "_rs1"}, 32'(rs1), 32'(e.e_rs1));
        chk({tag, "_rs2"}, 32'(rs2), 32'(e.e_rs2));
        chk({tag, "_rd"}, 32'(rd), 32'(e.e_rd));
        chk({tag, "_d1"}, d1, e.e_d1);
        chk({tag, "_d2"}, d2, e.e_d2);
        chk({tag, "_imm"}, imm, {e.e_d2[15:0], e.e_d1[15:0]});
        chk({tag, "_aluop"}, 32'(op), 32'(e.e_d1[3:0]));
        chk({tag, "_alusrc"}, 32'(asrc), 32'(e.e_rw));
        chk({tag, "_rw"}, 32'(rw), 32'(e.e_rw));
        chk({tag, "_mr"}, 32'(mr), 32'(e.e_mr));
        chk({tag, "_mw"}, 32'(mw), 32'(e.e_d2[0]));
        chk({tag, "_m2r"}, 32'(m2r), 32'(e.e_mr));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_addr"}, 32'({ex_rs1, ex_rs2, ex_rd}), 32'd0);
        chk({tag, "_d1"}, ex_rs1_data, 32'd0);
        chk({tag, "_d2"}, ex_rs2_data, 32'd0);
        chk({tag, "_imm"}, ex_imm, 32'd0);
        chk({tag, "_ctl"}, 32'({ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
        chk({tag, "_cnt"}, 32'(bubble_cnt), 32'd0);
        chk({tag, "_cnt_s"}, 32'(s_bubble_cnt), 32'd0);
    endtask

    vec_t tbl[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;

        //             v rs1 rs2 rd u1 u2 d1      d2      rw mr fl st | es ev erd ers1 ers2 ed1    ed2    erw emr cnt
        tbl[0]  = mk(1, 1, 0, 3, 1, 0, 'hAA,   0,      1, 0, 0, 0,   0, 1, 3, 1, 0, 'hAA,   0,      1, 0, 0);
        tbl[1]  = mk(1, 5, 6, 2, 1, 0, 'h100,  'h200,  1, 1, 0, 0,   0, 1, 2, 5, 6, 'h100,  'h200,  1, 1, 0);
        tbl[2]  = mk(1, 7, 2, 4, 1, 1, 'h11,   'h22,   1, 0, 0, 0,   1, 0, 0, 0, 0, 0,      0,      0, 0, 1);
        tbl[3]  = mk(1, 7, 2, 4, 1, 1, 'h11,   'h22,   1, 0, 0, 0,   0, 1, 4, 7, 2, 'h11,   'h22,   1, 0, 1);
        tbl[4]  = mk(1, 1, 1, 0, 1, 1, 1,      2,      1, 1, 0, 0,   0, 1, 0, 1, 1, 1,      2,      1, 1, 1);
        tbl[5]  = mk(1, 0, 3, 5, 1, 1, 'h33,   'h44,   1, 0, 0, 0,   0, 1, 5, 0, 3, 'h33,   'h44,   1, 0, 1);
        tbl[6]  = mk(1, 2, 3, 4, 1, 0, 5,      6,      1, 1, 0, 0,   0, 1, 4, 2, 3, 5,      6,      1, 1, 1);
        tbl[7]  = mk(1, 4, 1, 6, 0, 1, 'h55,   'h66,   1, 0, 0, 0,   0, 1, 6, 4, 1, 'h55,   'h66,   1, 0, 1);
        tbl[8]  = mk(1, 1, 1, 7, 1, 1, 7,      8,      1, 1, 0, 0,   0, 1, 7, 1, 1, 7,      8,      1, 1, 1);
        tbl[9]  = mk(0, 7, 0, 1, 1, 0, 9,      0,      0, 0, 0, 0,   0, 0, 1, 7, 0, 9,      0,      0, 0, 1);
        tbl[10] = mk(1, 1, 1, 7, 0, 0, 'hA,    'hB,    1, 1, 0, 0,   0, 1, 7, 1, 1, 'hA,    'hB,    1, 1, 1);
        tbl[11] = mk(1, 7, 7, 2, 1, 1, 1,      2,      1, 0, 1, 0,   0, 0, 0, 0, 0, 0,      0,      0, 0, 1);
        tbl[12] = mk(1, 0, 0, 3, 0, 0, 'hC,    'hD,    1, 1, 0, 0,   0, 1, 3, 0, 0, 'hC,    'hD,    1, 1, 1);
        tbl[13] = mk(1, 3, 0, 5, 1, 0, 'h77,   0,      1, 0, 0, 1,   1, 1, 3, 0, 0, 'hC,    'hD,    1, 1, 1);
        tbl[14] = mk(1, 3, 0, 5, 1, 0, 'h77,   0,      1, 0, 0, 0,   1, 0, 0, 0, 0, 0,      0,      0, 0, 2);
        tbl[15] = mk(1, 3, 0, 5, 1, 0, 'h77,   0,      1, 0, 0, 0,   0, 1, 5, 3, 0, 'h77,   0,      1, 0, 2);
        tbl[16] = mk(1, 1, 2, 6, 1, 1, 'h99,   'h98,   1, 1, 1, 1,   1, 0, 0, 0, 0, 0,      0,      0, 0, 2);
        tbl[17] = mk(1, 0, 0, 6, 0, 0, 1,      2,      1, 1, 0, 0,   0, 1, 6, 0, 0, 1,      2,      1, 1, 2);
        tbl[18] = mk(1, 2, 6, 1, 1, 0, 3,      4,      1, 0, 0, 0,   0, 1, 1, 2, 6, 3,      4,      1, 0, 2);

        // Reset with busy ID inputs
        rst = 1'b1;
        apply(ins(1, 1, 2, 3, 1, 1, 'hFFFF_FFFF, 'hA5A5_A5A5, 1, 1, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hi");
        chk("rst_hi_stall", 32'(stall_if_id), 32'd0);
        ext_stall = 1'b1;
        #1;
        chk("rst_hi_stall_ext", 32'(stall_if_id), 32'd1);
        @(negedge clk);
        apply(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_rel");

        // Table-driven vectors
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall_if_id), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d_s_stall", i), 32'(s_stall_if_id), 32'(tbl[i].e_stall));
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
                       ex_imm, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
                       ex_mem_to_reg, tbl[i]);
            check_outs($sformatf("v%0d_s", i), s_ex_valid, s_ex_rs1, s_ex_rs2, s_ex_rd, s_ex_rs1_data,
                       s_ex_rs2_data, s_ex_imm, s_ex_alu_op, s_ex_alu_src, s_ex_reg_write,
                       s_ex_mem_read, s_ex_mem_write, s_ex_mem_to_reg, tbl[i]);
            chk($sformatf("v%0d_cnt", i), 32'(bubble_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_cnt_s", i), 32'(s_bubble_cnt), 32'(sat3(int'(tbl[i].e_cnt))));
        end

        // Freeze for three cycles while ID keeps changing
        @(negedge clk);
        apply(ins(1, 3, 4, 5, 1, 1, 'h5678_1239, 'h4321_8765, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("frz_load_imm", ex_imm, 32'h8765_1239);
        chk("frz_load_op", 32'(ex_alu_op), 32'h9);
        chk("frz_load_mw", 32'(ex_mem_write), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            apply(ins(k % 2, k, k + 1, k + 2, 1, 1, 'h100 * (k + 1), 'h200 * (k + 1), 0, 1, 0, 1));
            #1;
            chk($sformatf("frz%0d_stall", k), 32'(stall_if_id), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("frz%0d_valid", k), 32'(ex_valid), 32'd1);
            chk($sformatf("frz%0d_rd", k), 32'(ex_rd), 32'd5);
            chk($sformatf("frz%0d_rs1", k), 32'(ex_rs1), 32'd3);
            chk($sformatf("frz%0d_d1", k), ex_rs1_data, 32'h5678_1239);
            chk($sformatf("frz%0d_d2", k), ex_rs2_data, 32'h4321_8765);
            chk($sformatf("frz%0d_imm", k), ex_imm, 32'h8765_1239);
            chk($sformatf("frz%0d_op", k), 32'(ex_alu_op), 32'h9);
            chk($sformatf("frz%0d_rw", k), 32'(ex_reg_write), 32'd1);
            chk($sformatf("frz%0d_mr", k), 32'(ex_mem_read), 32'd0);
        end
        @(negedge clk);
        apply(ins(1, 6, 7, 6, 0, 0, 'hF0F0_0003, 'h0F0F_0F0E, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("frz_rel_rd", 32'(ex_rd), 32'd6);
        chk("frz_rel_op", 32'(ex_alu_op), 32'h3);
        chk("frz_rel_imm", ex_imm, 32'h0F0E_0003);
        chk("frz_rel_mw", 32'(ex_mem_write), 32'd0);
        chk("frz_rel_rw", 32'(ex_reg_write), 32'd0);
        chk("frz_rel_cnt", 32'(bubble_cnt), 32'd2);

        // Repeated load-use pairs; the 3-bit counter must stick at 7
        exp_cnt = 2;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            apply(ins(1, 0, 0, 1, 0, 0, n, 0, 1, 1, 0, 0));
            @(posedge clk);
            @(negedge clk);
            apply(ins(1, 1, 0, 2, 1, 0, 'h40 + n, 0, 1, 0, 0, 0));
            #1;
            chk($sformatf("sat%0d_stall", n), 32'(stall_if_id), 32'd1);
            @(posedge clk);
            #1;
            exp_cnt++;
            chk($sformatf("sat%0d_valid", n), 32'(ex_valid), 32'd0);
            chk($sformatf("sat%0d_rw", n), 32'(ex_reg_write), 32'd0);
            chk($sformatf("sat%0d_cnt", n), 32'(bubble_cnt), 32'(exp_cnt));
            chk($sformatf("sat%0d_cnt_s", n), 32'(s_bubble_cnt), 32'(sat3(exp_cnt)));
        end

        // Reset arriving while a bubble is pending
        @(negedge clk);
        apply(ins(1, 0, 0, 3, 0, 0, 'h31, 'h32, 1, 1, 0, 0));
        @(posedge clk);
        @(negedge clk);
        apply(ins(1, 0, 3, 4, 0, 1, 'h41, 'h42, 1, 0, 0, 0));
        #1;
        chk("rbub_pre_stall", 32'(stall_if_id), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rbub_async");
        chk("rbub_async_stall", 32'(stall_if_id), 32'd0);
        @(posedge clk);
        #1;
        check_zero("rbub_edge");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rbub_rel_stall", 32'(stall_if_id), 32'd0);
        @(posedge clk);
        #1;
        chk("rbub_rel_valid", 32'(ex_valid), 32'd1);
        chk("rbub_rel_rd", 32'(ex_rd), 32'd4);
        chk("rbub_rel_rs2", 32'(ex_rs2), 32'd3);
        chk("rbub_rel_cnt", 32'(bubble_cnt), 32'd0);

        // Reset arriving during a freeze
        @(negedge clk);
        ext_stall = 1'b1;
        @(posedge clk);
        #1;
        chk("rfrz_hold_rd", 32'(ex_rd), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("rfrz_valid", 32'(ex_valid), 32'd0);
        chk("rfrz_rd", 32'(ex_rd), 32'd0);
        chk("rfrz_d2", ex_rs2_data, 32'd0);
        chk("rfrz_stall", 32'(stall_if_id), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        ext_stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
